// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-rate enable, h/v counters, sync/visible decodes and a once-per-frame tick.
// Geometry defaults to 640x480@60Hz from a 100 MHz board clock.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 783,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 514
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             ft_q, ft_d;

  always_comb begin
    pix_en = (div_q == DIV_LAST);
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
    h_d    = h_q;
    v_d    = v_q;
    ft_d   = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d  = '0;
        v_d  = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        // tick lands on the same edge both counters wrap to 0
        ft_d = (v_q == V_LAST);
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      ft_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      ft_q  <= ft_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign frame_tick = ft_q;
  assign hSync      = ~(h_q < 10'(H_SYNC));
  assign vSync      = ~(v_q < 10'(V_SYNC));
  assign bright     = (h_q >= 10'(H_VIS_START)) && (h_q <= 10'(H_VIS_END)) &&
                      (v_q >= 10'(V_VIS_START)) && (v_q <= 10'(V_VIS_END));

endmodule
